// File: rtl/imem_port_arbiter.sv
// Two-port arbiter (fetch F, loader L) in front of one synchronous-read instruction memory.
// Optional range/alignment checking with f_err/l_err outputs when IMEM_ARB_RANGECHK_EN is defined.
module imem_port_arbiter #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          f_req,
  input  logic [31:0]   f_addr,
  output logic          f_gnt,
  output logic          f_rvalid,
  output logic [DW-1:0] f_rdata,
  input  logic          l_req,
  input  logic          l_we,
  input  logic [31:0]   l_addr,
  input  logic [DW-1:0] l_wdata,
  input  logic          l_lock,
  output logic          l_gnt,
  output logic          l_rvalid,
  output logic [DW-1:0] l_rdata,
  output logic          locked,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
`ifdef IMEM_ARB_RANGECHK_EN
  output logic          f_err,
  output logic          l_err,
`endif
  input  logic [DW-1:0] m_rdata
);

  // Handshake: a request is held until its gnt is seen high in the same cycle;
  // read data follows exactly one cycle after a granted read, flagged by rvalid.

  typedef enum logic {ST_SHARED = 1'b0, ST_LOCKED = 1'b1} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_prio_l;
  logic          w_f_win;
  logic          w_l_win;
  logic          w_f_bad;
  logic          w_l_bad;
  logic          r_f_rd;
  logic          r_l_rd;
  logic          r_f_err;
  logic          r_l_err;
  logic [DW-1:0] r_f_hold;
  logic [DW-1:0] r_l_hold;

`ifdef IMEM_ARB_RANGECHK_EN
  assign w_f_bad = (f_addr[31:AW+2] != '0) || (f_addr[1:0] != 2'b00);
  assign w_l_bad = (l_addr[31:AW+2] != '0) || (l_addr[1:0] != 2'b00);
  assign f_err   = !reset && r_f_err;
  assign l_err   = !reset && r_l_err;
`else
  logic w_unused;
  assign w_unused = ^{f_addr[31:AW+2], f_addr[1:0], l_addr[31:AW+2], l_addr[1:0]};
  assign w_f_bad  = 1'b0;
  assign w_l_bad  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_SHARED;
    else       r_state <= w_state_nxt;
  end

  // Entering LOCKED waits for a cycle with no F read issued, so lock never races a fetch grant.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_SHARED: if (l_lock && !w_f_win) w_state_nxt = ST_LOCKED;
      ST_LOCKED: if (!l_lock)            w_state_nxt = ST_SHARED;
      default:   w_state_nxt = ST_SHARED;
    endcase
  end

  always_comb begin
    w_f_win = 1'b0;
    w_l_win = 1'b0;
    if (!reset) begin
      if (r_state == ST_LOCKED) begin
        w_l_win = l_req;
      end else begin
        w_f_win = f_req && (!l_req || !r_prio_l);
        w_l_win = l_req && (!f_req ||  r_prio_l);
      end
    end
    f_gnt   = w_f_win;
    l_gnt   = w_l_win;
    locked  = !reset && (r_state == ST_LOCKED);
    m_en    = (w_f_win && !w_f_bad) || (w_l_win && !w_l_bad);
    m_we    = w_l_win && l_we && !w_l_bad;
    m_addr  = '0;
    m_wdata = '0;
    if (w_f_win)      m_addr = f_addr[AW+1:2];
    else if (w_l_win) m_addr = l_addr[AW+1:2];
    if (w_l_win && l_we) m_wdata = l_wdata;
  end

  // Priority only moves on contended SHARED grants, towards the port that lost.
  always_ff @(posedge clk) begin
    if (reset) r_prio_l <= 1'b0;
    else if (r_state == ST_SHARED && f_req && l_req) r_prio_l <= ~r_prio_l;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_f_rd  <= 1'b0;
      r_l_rd  <= 1'b0;
      r_f_err <= 1'b0;
      r_l_err <= 1'b0;
    end else begin
      r_f_rd  <= w_f_win && !w_f_bad;
      r_l_rd  <= w_l_win && !l_we && !w_l_bad;
      r_f_err <= w_f_win && w_f_bad;
      r_l_err <= w_l_win && w_l_bad;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_f_hold <= '0;
      r_l_hold <= '0;
    end else begin
      if (r_f_rd)       r_f_hold <= m_rdata;
      else if (r_f_err) r_f_hold <= '0;
      if (r_l_rd)       r_l_hold <= m_rdata;
      else if (r_l_err) r_l_hold <= '0;
    end
  end

  always_comb begin
    f_rvalid = !reset && (r_f_rd || r_f_err);
    l_rvalid = !reset && (r_l_rd || r_l_err);
    f_rdata  = r_f_hold;
    l_rdata  = r_l_hold;
    if (r_f_rd)       f_rdata = m_rdata;
    else if (r_f_err) f_rdata = '0;
    if (r_l_rd)       l_rdata = m_rdata;
    else if (r_l_err) l_rdata = '0;
    if (reset) begin
      f_rdata = '0;
      l_rdata = '0;
    end
  end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter with a behavioural write-first memory and per-port
// expected-data queues drained by a monitor. Build with IMEM_ARB_RANGECHK_EN for err checks.
module tb_imem_port_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          f_req, l_req, l_we, l_lock;
  logic [31:0]   f_addr, l_addr;
  logic [DW-1:0] l_wdata;
  logic          f_gnt, f_rvalid, l_gnt, l_rvalid, locked, m_en, m_we;
  logic [DW-1:0] f_rdata, l_rdata, m_wdata, m_rdata;
  logic [AW-1:0] m_addr;
`ifdef IMEM_ARB_RANGECHK_EN
  logic          f_err, l_err;
`endif

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] exp_f_q [$];
  logic [DW-1:0] exp_l_q [$];
  int n_chk  = 0;
  int n_pass = 0;

  imem_port_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata), .l_lock(l_lock),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata), .locked(locked),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
`ifdef IMEM_ARB_RANGECHK_EN
    .f_err(f_err), .l_err(l_err),
`endif
    .m_rdata(m_rdata)
  );

  // clock / reset
  always #5 clk = ~clk;

  // write-first synchronous memory model
  always @(posedge clk) begin
    if (m_en) begin
      if (m_we) begin
        mem[m_addr] <= m_wdata;
        m_rdata     <= m_wdata;
      end else begin
        m_rdata <= mem[m_addr];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (f_rvalid) begin
      if (exp_f_q.size() == 0) begin
        n_chk++;
        $display("FAIL f_unexpected_rvalid: got data 0x%08h expected no response at %0t", f_rdata, $time);
      end else chk("f_rdata", f_rdata, exp_f_q.pop_front());
    end
    if (l_rvalid) begin
      if (exp_l_q.size() == 0) begin
        n_chk++;
        $display("FAIL l_unexpected_rvalid: got data 0x%08h expected no response at %0t", l_rdata, $time);
      end else chk("l_rdata", l_rdata, exp_l_q.pop_front());
    end
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h100 + i;
    m_rdata = '0;
    reset = 1'b1; f_req = 1'b1; f_addr = 32'h0;
    l_req = 1'b0; l_we = 1'b0; l_addr = 32'h0; l_wdata = '0; l_lock = 1'b0;

    // reset with f_req held
    repeat (2) begin
      @(negedge clk);
      chk("rst_f_gnt", f_gnt, 0); chk("rst_l_gnt", l_gnt, 0);
      chk("rst_m_en", m_en, 0);   chk("rst_f_rvalid", f_rvalid, 0);
      chk("rst_locked", locked, 0);
      next_cycle();
    end

    // fetch stream 0x0, 0x4, 0x8
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      f_addr = 32'(4 * i);
      @(negedge clk);
      chk("fetch_gnt", f_gnt, 1); chk("fetch_m_en", m_en, 1);
      chk("fetch_m_addr", 32'(m_addr), 32'(i)); chk("fetch_latency", f_rvalid, (i > 0) ? 1 : 0);
      exp_f_q.push_back(32'h100 + i);
      next_cycle();
    end

    // reset while a fetch is in flight
    f_addr = 32'hC;
    @(negedge clk);
    chk("fetch3_gnt", f_gnt, 1);
    next_cycle();
    reset = 1'b1; f_req = 1'b0;
    @(negedge clk);
    chk("rst_mid_rvalid", f_rvalid, 0);
    next_cycle();

    // contention from reset: F, L, F, L
    reset = 1'b0; f_req = 1'b1; f_addr = 32'h0; l_req = 1'b1; l_we = 1'b0; l_addr = 32'h40;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("cont_f_gnt", f_gnt, (c % 2 == 0) ? 1 : 0);
      chk("cont_l_gnt", l_gnt, (c % 2 == 1) ? 1 : 0);
      if (c % 2 == 0) exp_f_q.push_back(32'h100);
      else begin
        chk("cont_l_m_addr", 32'(m_addr), 32'd16);
        exp_l_q.push_back(32'h110);
      end
      if (c == 2) begin
        chk("cont_l_rvalid", l_rvalid, 1);
        chk("cont_f_rdata_hold", f_rdata, 32'h100);
      end
      next_cycle();
    end
    f_req = 1'b0; l_req = 1'b0;
    next_cycle();

    // loader write then fetch of the same word
    l_req = 1'b1; l_we = 1'b1; l_addr = 32'h14; l_wdata = 32'h55AA;
    @(negedge clk);
    chk("wr_l_gnt", l_gnt, 1); chk("wr_m_we", m_we, 1); chk("wr_m_wdata", m_wdata, 32'h55AA);
    next_cycle();
    l_req = 1'b0; l_we = 1'b0; f_req = 1'b1; f_addr = 32'h14;
    @(negedge clk);
    chk("wf_f_gnt", f_gnt, 1); chk("wr_no_l_rvalid", l_rvalid, 0);
    exp_f_q.push_back(32'h55AA);
    next_cycle();
    f_req = 1'b0;
`ifndef IMEM_ARB_RANGECHK_EN
    l_req = 1'b1; l_addr = 32'h1014;
    @(negedge clk);
    chk("wrap_m_addr", 32'(m_addr), 32'd5);
    exp_l_q.push_back(32'h55AA);
    next_cycle();
    l_req = 1'b0;
`endif
    next_cycle();

    // lock and download
    l_lock = 1'b1;
    @(negedge clk);
    chk("lock_pre_locked", locked, 0);
    next_cycle();
    f_req = 1'b1; f_addr = 32'h10; l_req = 1'b1; l_we = 1'b1; l_addr = 32'h10; l_wdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("lock_locked", locked, 1); chk("lock_f_gnt", f_gnt, 0); chk("lock_l_gnt", l_gnt, 1);
    chk("lock_m_we", m_we, 1); chk("lock_m_addr", 32'(m_addr), 32'd4);
    chk("lock_m_wdata", m_wdata, 32'hDEADBEEF);
    next_cycle();
    l_req = 1'b0; l_we = 1'b0;
    @(negedge clk);
    chk("lock_hold_f_gnt", f_gnt, 0); chk("lock_hold_locked", locked, 1);
    next_cycle();
    l_lock = 1'b0;
    @(negedge clk);
    chk("unlock_edge_f_gnt", f_gnt, 0);
    next_cycle();
    @(negedge clk);
    chk("unlock_f_gnt", f_gnt, 1); chk("unlock_locked", locked, 0);
    exp_f_q.push_back(32'hDEADBEEF);
    next_cycle();
    f_req = 1'b0;
    next_cycle();

    // lock requested in the same cycle as a fetch grant
    f_req = 1'b1; f_addr = 32'h8; l_lock = 1'b1;
    @(negedge clk);
    chk("inflight_f_gnt", f_gnt, 1);
    exp_f_q.push_back(32'h102);
    next_cycle();
    f_req = 1'b0;
    @(negedge clk);
    chk("inflight_f_rvalid", f_rvalid, 1);
    next_cycle();
    @(negedge clk);
    chk("inflight_locked", locked, 1);
    next_cycle();
    l_lock = 1'b0;
    next_cycle();

`ifdef IMEM_ARB_RANGECHK_EN
    f_req = 1'b1; f_addr = 32'h1000;
    @(negedge clk);
    chk("rc_f_gnt", f_gnt, 1); chk("rc_f_m_en", m_en, 0);
    exp_f_q.push_back(32'h0);
    next_cycle();
    f_req = 1'b0;
    @(negedge clk);
    chk("rc_f_err", f_err, 1); chk("rc_f_rvalid", f_rvalid, 1);
    next_cycle();
    l_req = 1'b1; l_we = 1'b1; l_addr = 32'h2; l_wdata = 32'h12345678;
    @(negedge clk);
    chk("rc_l_gnt", l_gnt, 1); chk("rc_l_m_en", m_en, 0);
    exp_l_q.push_back(32'h0);
    next_cycle();
    l_req = 1'b0; l_we = 1'b0; f_req = 1'b1; f_addr = 32'h0;
    @(negedge clk);
    chk("rc_l_err", l_err, 1); chk("rc_l_rvalid", l_rvalid, 1);
    exp_f_q.push_back(32'h100);
    next_cycle();
    f_req = 1'b0;
`endif

    repeat (3) next_cycle();
    chk("f_queue_drained", 32'(exp_f_q.size()), 0);
    chk("l_queue_drained", 32'(exp_l_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
